// File: rtl/mem_bus_arbiter_if.sv
// Bundle of fetch port, data port and memory-side signals around mem_bus_arbiter.
// The arbiter connects through the slave modport; requesters and memory use master.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 24
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_ack;
    logic [31:0]       f_rdata;
    logic              f_err;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_ack;
    logic [31:0]       d_rdata;
    logic              d_err;

    logic              m_start;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wdata;
    logic              m_done;
    logic [31:0]       m_rdata;
    logic              m_abort;
    logic              busy;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, m_done, m_rdata,
        output f_ack, f_rdata, f_err, d_ack, d_rdata, d_err,
               m_start, m_we, m_addr, m_wdata, m_abort, busy
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, m_done, m_rdata,
        input  f_ack, f_rdata, f_err, d_ack, d_rdata, d_err,
               m_start, m_we, m_addr, m_wdata, m_abort, busy
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between a fetch and a data requester,
// with a per-transaction timeout that aborts the memory access.
//   state | meaning
//   IDLE  | no transaction; arbitrate and latch winner's request
//   ISSUE | m_start pulse high, timeout counter cleared
//   WAIT  | waiting for m_done or timeout
module mem_bus_arbiter #(
    parameter int ADDR_W  = 24,
    parameter int TIMEOUT = 64
) (
    input logic            clk,
    input logic            rst_n,
    mem_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t            r_state;
    logic              r_last_d;
    logic              r_win_d;
    logic [7:0]        r_cnt;
    logic              r_f_ack, r_f_err, r_d_ack, r_d_err;
    logic [31:0]       r_f_rdata, r_d_rdata;
    logic              r_m_start, r_m_we, r_m_abort;
    logic [ADDR_W-1:0] r_m_addr;
    logic [31:0]       r_m_wdata;

    logic w_f_req, w_d_req, w_grant_d;

    // A requester still holds req during its ack cycle; mask it so it is not re-granted.
    assign w_f_req   = bus.f_req & ~r_f_ack;
    assign w_d_req   = bus.d_req & ~r_d_ack;
    assign w_grant_d = w_d_req & (~w_f_req | ~r_last_d);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state   <= IDLE;
            r_last_d  <= 1'b1;
            r_win_d   <= 1'b0;
            r_cnt     <= '0;
            r_f_ack   <= 1'b0;
            r_f_err   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_d_err   <= 1'b0;
            r_f_rdata <= '0;
            r_d_rdata <= '0;
            r_m_start <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_abort <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
        end else begin
            r_f_ack   <= 1'b0;
            r_f_err   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_d_err   <= 1'b0;
            r_m_start <= 1'b0;
            r_m_abort <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_f_req | w_d_req) begin
                        r_win_d   <= w_grant_d;
                        r_last_d  <= w_grant_d;
                        r_m_addr  <= w_grant_d ? bus.d_addr : bus.f_addr;
                        r_m_we    <= w_grant_d & bus.d_we;
                        r_m_wdata <= w_grant_d ? bus.d_wdata : '0;
                        r_m_start <= 1'b1;
                        r_state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    // Completion takes priority over a timeout landing in the same cycle.
                    if (bus.m_done) begin
                        if (r_win_d) begin
                            r_d_ack <= 1'b1;
                            if (!r_m_we) r_d_rdata <= bus.m_rdata;
                        end else begin
                            r_f_ack   <= 1'b1;
                            r_f_rdata <= bus.m_rdata;
                        end
                        r_state <= IDLE;
                    end else if (r_cnt == TO_LAST) begin
                        r_cnt     <= r_cnt + 8'd1;
                        r_m_abort <= 1'b1;
                        if (r_win_d) begin
                            r_d_ack   <= 1'b1;
                            r_d_err   <= 1'b1;
                            r_d_rdata <= '0;
                        end else begin
                            r_f_ack   <= 1'b1;
                            r_f_err   <= 1'b1;
                            r_f_rdata <= '0;
                        end
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.f_ack   = r_f_ack;
    assign bus.f_err   = r_f_err;
    assign bus.f_rdata = r_f_rdata;
    assign bus.d_ack   = r_d_ack;
    assign bus.d_err   = r_d_err;
    assign bus.d_rdata = r_d_rdata;
    assign bus.m_start = r_m_start;
    assign bus.m_we    = r_m_we;
    assign bus.m_addr  = r_m_addr;
    assign bus.m_wdata = r_m_wdata;
    assign bus.m_abort = r_m_abort;
    assign bus.busy    = (r_state != IDLE);
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: arbitration order, read/write paths,
// timeout boundary and mid-transaction reset, with hand-computed expectations.
module tb_mem_bus_arbiter;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_W(24)) bus();

    mem_bus_arbiter #(.ADDR_W(24), .TIMEOUT(64)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_start  = 0, n_abort = 0, n_fack = 0, n_dack = 0, n_dual = 0, n_errbad = 0;

    always @(negedge clk) begin
        if (bus.m_start === 1'b1) n_start <= n_start + 1;
        if (bus.m_abort === 1'b1) n_abort <= n_abort + 1;
        if (bus.f_ack === 1'b1)   n_fack  <= n_fack + 1;
        if (bus.d_ack === 1'b1)   n_dack  <= n_dack + 1;
        if (bus.f_ack === 1'b1 && bus.d_ack === 1'b1) n_dual <= n_dual + 1;
        if ((bus.f_err === 1'b1 && bus.f_ack !== 1'b1) ||
            (bus.d_err === 1'b1 && bus.d_ack !== 1'b1)) n_errbad <= n_errbad + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns at the negedge where m_start is seen; k = negedges waited.
    task automatic wait_start(input string tag, output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.m_start !== 1'b1 && k < 50);
        chk(tag, 32'(bus.m_start), 32'd1);
    endtask

    // Called at the negedge of the m_start cycle; m_done is high lat cycles later.
    task automatic mem_respond(input int lat, input logic [31:0] rd);
        repeat (lat) @(posedge clk);
        #1;
        bus.m_done  = 1'b1;
        bus.m_rdata = rd;
        tick();
        bus.m_done  = 1'b0;
    endtask

    initial begin
        int k, base_s, base_a, base_f, base_d;
        logic exp_d;
        logic [31:0] rd;
        bus.f_req = 0; bus.f_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.m_done = 0; bus.m_rdata = '0;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        chk("rst_pulses", 32'({bus.f_ack, bus.f_err, bus.d_ack, bus.d_err,
                              bus.m_start, bus.m_abort, bus.busy, bus.m_we}), 32'd0);
        chk("rst_f_rdata", bus.f_rdata, 32'd0);
        chk("rst_d_rdata", bus.d_rdata, 32'd0);
        chk("rst_m_addr", 32'(bus.m_addr), 32'd0);
        chk("rst_m_wdata", bus.m_wdata, 32'd0);
        tick();
        rst_n = 1'b0;
        tick();

        // Simultaneous requests from reset alternate fetch, data, fetch, data
        for (int r = 0; r < 2; r++) begin
            tick();
            bus.f_addr = 24'h000A10 + 24'(r);
            bus.d_addr = 24'h000D20 + 24'(r);
            bus.d_we   = 1'b0;
            bus.f_req  = 1'b1;
            bus.d_req  = 1'b1;
            for (int t = 0; t < 2; t++) begin
                exp_d = (t == 1);
                wait_start("rr_start", k);
                chk("rr_addr", 32'(bus.m_addr),
                    exp_d ? 32'h000D20 + 32'(r) : 32'h000A10 + 32'(r));
                chk("rr_we", 32'(bus.m_we), 32'd0);
                rd = exp_d ? 32'hD000_0000 + 32'(r) : 32'hF000_0000 + 32'(r);
                mem_respond(2, rd);
                @(negedge clk);
                chk("rr_f_ack", 32'(bus.f_ack), 32'(!exp_d));
                chk("rr_d_ack", 32'(bus.d_ack), 32'(exp_d));
                if (exp_d) begin
                    chk("rr_d_rdata", bus.d_rdata, rd);
                    bus.d_req = 1'b0;
                end else begin
                    chk("rr_f_rdata", bus.f_rdata, rd);
                    bus.f_req = 1'b0;
                end
            end
        end
        repeat (3) @(negedge clk);
        chk("rr_dual_ack", 32'(n_dual), 32'd0);

        // Single fetch read, m_done 3 cycles after m_start
        tick();
        base_s = n_start;
        bus.f_addr = 24'h000100;
        bus.f_req  = 1'b1;
        wait_start("rd_start", k);
        chk("rd_start_latency", 32'(k), 32'd2);
        chk("rd_m_addr", 32'(bus.m_addr), 32'h000100);
        chk("rd_m_we", 32'(bus.m_we), 32'd0);
        chk("rd_busy", 32'(bus.busy), 32'd1);
        mem_respond(3, 32'hDEADBEEF);
        @(negedge clk);
        chk("rd_f_ack", 32'(bus.f_ack), 32'd1);
        chk("rd_f_rdata", bus.f_rdata, 32'hDEADBEEF);
        chk("rd_f_err", 32'(bus.f_err), 32'd0);
        chk("rd_busy_idle", 32'(bus.busy), 32'd0);
        bus.f_req = 1'b0;
        @(negedge clk);
        chk("rd_f_ack_pulse", 32'(bus.f_ack), 32'd0);
        @(negedge clk);
        chk("rd_one_start", 32'(n_start - base_s), 32'd1);

        // Data write; requester inputs change after grant
        tick();
        bus.d_req = 1'b1; bus.d_we = 1'b1;
        bus.d_addr = 24'h0000F0; bus.d_wdata = 32'h12345678;
        wait_start("wr_start", k);
        bus.d_addr = 24'h000000; bus.d_wdata = 32'hFFFF0000; bus.d_we = 1'b0;
        @(negedge clk);
        chk("wr_m_we", 32'(bus.m_we), 32'd1);
        chk("wr_m_wdata", bus.m_wdata, 32'h12345678);
        chk("wr_m_addr", 32'(bus.m_addr), 32'h0000F0);
        mem_respond(1, 32'hBAD0BAD0);
        @(negedge clk);
        chk("wr_d_ack", 32'(bus.d_ack), 32'd1);
        chk("wr_d_err", 32'(bus.d_err), 32'd0);
        chk("wr_d_rdata_kept", bus.d_rdata, 32'hD000_0001);
        chk("wr_f_rdata_kept", bus.f_rdata, 32'hDEADBEEF);
        bus.d_req = 1'b0;

        // m_done in ISSUE ignored; m_done on the last timeout cycle completes normally
        tick();
        base_a = n_abort; base_d = n_dack;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 24'h000031;
        wait_start("bd_start", k);
        bus.m_done  = 1'b1;
        bus.m_rdata = 32'h11111111;
        tick();
        bus.m_done  = 1'b0;
        repeat (63) @(posedge clk);
        #1;
        bus.m_done  = 1'b1;
        bus.m_rdata = 32'hA5A50031;
        tick();
        bus.m_done  = 1'b0;
        @(negedge clk);
        chk("bd_d_ack", 32'(bus.d_ack), 32'd1);
        chk("bd_d_err", 32'(bus.d_err), 32'd0);
        chk("bd_m_abort", 32'(bus.m_abort), 32'd0);
        chk("bd_d_rdata", bus.d_rdata, 32'hA5A50031);
        bus.d_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("bd_ack_count", 32'(n_dack - base_d), 32'd1);
        chk("bd_no_abort", 32'(n_abort - base_a), 32'd0);

        // Timeout: no m_done
        tick();
        base_a = n_abort;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 24'h000042;
        wait_start("to_start", k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.m_abort !== 1'b1 && k < 100);
        chk("to_cycles_after_wait_entry", 32'(k - 1), 32'd64);
        chk("to_d_ack", 32'(bus.d_ack), 32'd1);
        chk("to_d_err", 32'(bus.d_err), 32'd1);
        chk("to_d_rdata", bus.d_rdata, 32'd0);
        chk("to_f_ack", 32'(bus.f_ack), 32'd0);
        bus.d_req = 1'b0;
        @(negedge clk);
        chk("to_after", 32'({bus.busy, bus.m_abort, bus.d_ack, bus.d_err}), 32'd0);
        chk("to_one_abort", 32'(n_abort - base_a), 32'd1);

        // Reset during WAIT, then a stray m_done
        tick();
        bus.f_req = 1'b1; bus.f_addr = 24'h000043;
        wait_start("mr_start", k);
        repeat (3) @(negedge clk);
        chk("mr_busy_wait", 32'(bus.busy), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        bus.f_req = 1'b0;
        rst_n = 1'b0;
        base_s = n_start; base_a = n_abort; base_f = n_fack; base_d = n_dack;
        bus.m_done  = 1'b1;
        bus.m_rdata = 32'h77777777;
        tick();
        bus.m_done  = 1'b0;
        repeat (5) @(negedge clk);
        chk("mr_no_ack", 32'((n_fack - base_f) + (n_dack - base_d)), 32'd0);
        chk("mr_no_abort", 32'(n_abort - base_a), 32'd0);
        chk("mr_no_start", 32'(n_start - base_s), 32'd0);
        chk("mr_busy", 32'(bus.busy), 32'd0);
        chk("mr_f_rdata", bus.f_rdata, 32'd0);
        chk("mr_d_rdata", bus.d_rdata, 32'd0);
        chk("mr_m_addr", 32'(bus.m_addr), 32'd0);

        chk("glob_dual_ack", 32'(n_dual), 32'd0);
        chk("glob_err_without_ack", 32'(n_errbad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, memory address width.
REQ-002 SHALL have parameter TIMEOUT, default 64, maximum cycles from m_start to m_done before abort; legal range 2..255.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-high.
REQ-005 f_req  input  1  fetch port request; held high until f_ack.
REQ-006 f_addr  input  ADDR_W  fetch address.
REQ-007 f_ack  output  1  fetch completion pulse, one cycle.
REQ-008 f_rdata  output  32  fetch read data.
REQ-009 f_err  output  1  fetch timeout flag, valid with f_ack.
REQ-010 d_req  input  1  data port request; held high until d_ack.
REQ-011 d_we  input  1  data port write enable.
REQ-012 d_addr  input  ADDR_W  data address.
REQ-013 d_wdata  input  32  data write value.
REQ-014 d_ack  output  1  data completion pulse, one cycle.
REQ-015 d_rdata  output  32  data read data.
REQ-016 d_err  output  1  data timeout flag, valid with d_ack.
REQ-017 m_start  output  1  one-cycle pulse launching a memory transaction.
REQ-018 m_we  output  1  memory write enable.
REQ-019 m_addr  output  ADDR_W  memory address.
REQ-020 m_wdata  output  32  memory write data.
REQ-021 m_done  input  1  memory completion pulse.
REQ-022 m_rdata  input  32  memory read data, valid with m_done.
REQ-023 m_abort  output  1  one-cycle pulse cancelling the outstanding transaction.
REQ-024 busy  output  1  high whenever state is not IDLE.

Function
REQ-025 SHALL implement FSM states IDLE, ISSUE, WAIT.
REQ-026 IDLE: if f_req or d_req high, select winner, latch its addr/we/wdata onto m_addr/m_we/m_wdata (fetch: m_we=0, m_wdata=0), go to ISSUE; else stay.
REQ-027 Arbitration: single requester wins; both requesting, winner is the port not granted last (round-robin via last_grant register).
REQ-028 ISSUE: m_start=1 for exactly this cycle, clear timeout counter, go to WAIT.
REQ-029 WAIT: on m_done, capture m_rdata into winner's rdata (reads only; writes leave rdata unchanged), pulse winner's ack next cycle with err=0, return to IDLE.
REQ-030 WAIT: counter increments each cycle without m_done; on reaching TIMEOUT, pulse m_abort and winner's ack with err=1, winner's rdata=0, return to IDLE.
REQ-031 m_done in the same cycle the counter reaches TIMEOUT SHALL be treated as normal completion; no abort.
REQ-032 m_done in IDLE or ISSUE SHALL be ignored.
REQ-033 Requester input changes after grant SHALL not affect the transaction in flight.
REQ-034 Latency: request sampled in IDLE at cycle N -> m_start at N+1; m_done sampled at cycle M -> ack at M+1; state is IDLE at cycle M+1.
REQ-035 m_addr/m_we/m_wdata SHALL hold latched values until the next grant; rdata outputs hold until next ack of that port.
REQ-036 Only one ack SHALL be high in any cycle; err SHALL be 0 whenever its ack is 0.

Reset
REQ-037 Reset SHALL force state IDLE, last_grant=data (fetch wins first tie), counter 0, and every output 0.
REQ-038 Reset mid-transaction SHALL abandon it with no ack and no m_abort.

Verification
REQ-039 f_req only, f_addr=0x000100, m_done 3 cycles after m_start with m_rdata=0xDEADBEEF -> one m_start, m_addr=0x000100, m_we=0, f_ack one cycle later, f_rdata=0xDEADBEEF, f_err=0.
REQ-040 f_req and d_req raised same cycle from reset, repeated -> grants alternate fetch, data, fetch, data; never two acks in one cycle.
REQ-041 d_req, d_we=1, d_addr=0x0000F0, d_wdata=0x12345678 -> m_we=1, m_wdata=0x12345678, d_ack, d_rdata unchanged.
REQ-042 m_done never asserted, TIMEOUT=64 -> m_abort and d_ack with d_err=1 exactly 64 cycles after WAIT entry, busy low next cycle.
REQ-043 rst_n asserted during WAIT, m_done pulsed after release -> no ack, no abort, all outputs 0, busy=0.
